tcp_vlg_ack_proc: RTL and testbench

Transmit-side acknowledgement processor for the TCP engine. It is the counterpart of the pure-ack generator on the receive path. It consumes remote acknowledgement numbers from parsed incoming segments and tracks the unacknowledged window between the remote ack and the local sequence. It requests retransmission on three duplicate acks (fast retransmit) or on timeout with exponential backoff, and flags connection abort when the retry budget is exhausted. It sits between the TCP RX parser and the TX retransmission/queue logic.

---
 rtl/tcp_vlg_ack_proc.sv | 178 +++++++++++++++++
 tb/tb_tcp_vlg_ack_proc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_vlg_ack_proc.sv
// rtl/tcp_vlg_ack_proc.sv - TX-side ack tracking, fast/timeout retransmit requests, retry abort
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   init, init_seq             load rem_ack/loc_seq and clear all state
//   connected                  enables ack processing, timer and FSM
//   rx_val, rx_ack_flag,
//   rx_ack_num, rx_pld_len     parsed metadata of a received segment
//   tx_sent, tx_seq_end        new data segment sent, local sequence after it
//   rtx_req, rtx_fast, rtx_seq retransmission request (fast/timeout) and start sequence
//   rtx_done                   TX logic has re-sent from rtx_seq
//   rem_ack, in_flight,
//   all_acked                  ack window status
//   abort                      retry budget exhausted (sticky until init/reset)
module tcp_vlg_ack_proc #(
  parameter int RTO_INIT    = 1250,
  parameter int MAX_BACKOFF = 4,
  parameter int RETRIES     = 6,
  parameter int DUP_ACKS    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic [31:0] init_seq,
  input  logic        connected,
  input  logic        rx_val,
  input  logic        rx_ack_flag,
  input  logic [31:0] rx_ack_num,
  input  logic [15:0] rx_pld_len,
  input  logic        tx_sent,
  input  logic [31:0] tx_seq_end,
  output logic        rtx_req,
  output logic        rtx_fast,
  output logic [31:0] rtx_seq,
  input  logic        rtx_done,
  output logic [31:0] rem_ack,
  output logic [31:0] in_flight,
  output logic        all_acked,
  output logic        abort
);

  localparam int BW = ($clog2(MAX_BACKOFF + 1) < 1) ? 1 : $clog2(MAX_BACKOFF + 1);
  localparam int RW = ($clog2(RETRIES + 1) < 1) ? 1 : $clog2(RETRIES + 1);
  localparam int DW = ($clog2(DUP_ACKS + 1) < 1) ? 1 : $clog2(DUP_ACKS + 1);

  localparam logic [31:0]   RTO_BASE = 32'(RTO_INIT);
  localparam logic [BW-1:0] BO_MAX   = BW'(MAX_BACKOFF);
  localparam logic [RW-1:0] RET_LAST = RW'(RETRIES - 1);
  localparam logic [DW-1:0] DUP_MAX  = DW'(DUP_ACKS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RTX, S_ABORT} state_t;

  state_t        state;
  logic [31:0]   loc_seq;
  logic [31:0]   timer;
  logic [BW-1:0] backoff;
  logic [RW-1:0] retries;
  logic [DW-1:0] dup_cnt;

  logic [31:0]   d, f, rto_lim;
  logic          ack_ok, ack_new, ack_dup, fast_trig;
  logic [DW-1:0] dup_next;

  always_comb begin
    d        = rx_ack_num - rem_ack;
    f        = loc_seq - rem_ack;
    ack_ok   = rx_val && rx_ack_flag && connected;
    // Window check in modular space: a valid ack lies in (rem_ack, loc_seq].
    ack_new  = ack_ok && (d != 32'd0) && (d <= f);
    ack_dup  = ack_ok && (d == 32'd0) && (rx_pld_len == 16'd0) && (f != 32'd0);
    dup_next = (ack_dup && (dup_cnt != DUP_MAX)) ? dup_cnt + DW'(1) : dup_cnt;
    // Fires only on the dup that takes the counter up to the threshold.
    fast_trig = ack_dup && (dup_cnt != DUP_MAX) && (dup_next == DUP_MAX);
    rto_lim  = (RTO_BASE << backoff) - 32'd1;
  end

  assign in_flight = f;
  assign all_acked = (f == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rem_ack  <= 32'd0;
      loc_seq  <= 32'd0;
      timer    <= 32'd0;
      backoff  <= '0;
      retries  <= '0;
      dup_cnt  <= '0;
      rtx_req  <= 1'b0;
      rtx_fast <= 1'b0;
      rtx_seq  <= 32'd0;
      abort    <= 1'b0;
    end else if (init) begin
      state    <= S_IDLE;
      rem_ack  <= init_seq;
      loc_seq  <= init_seq;
      timer    <= 32'd0;
      backoff  <= '0;
      retries  <= '0;
      dup_cnt  <= '0;
      rtx_req  <= 1'b0;
      rtx_fast <= 1'b0;
      rtx_seq  <= 32'd0;
      abort    <= 1'b0;
    end else begin
      if (tx_sent) loc_seq <= tx_seq_end;

      if (connected) begin
        if (ack_new) begin
          rem_ack <= rx_ack_num;
          dup_cnt <= '0;
          timer   <= 32'd0;
          backoff <= '0;
          retries <= '0;
        end else begin
          dup_cnt <= dup_next;
        end

        case (state)
          S_IDLE: begin
            if (!all_acked) begin
              state <= S_WAIT;
              timer <= 32'd0;
            end
          end

          S_WAIT: begin
            if (all_acked) begin
              state <= S_IDLE;
            end else if (ack_new) begin
              // New ack outranks a coincident timeout; timer already cleared.
            end else if (fast_trig) begin
              state    <= S_RTX;
              rtx_req  <= 1'b1;
              rtx_fast <= 1'b1;
              rtx_seq  <= rem_ack;
            end else if (timer == rto_lim) begin
              if (retries == RET_LAST) begin
                state   <= S_ABORT;
                abort   <= 1'b1;
                rtx_req <= 1'b0;
              end else begin
                state    <= S_RTX;
                rtx_req  <= 1'b1;
                rtx_fast <= 1'b0;
                rtx_seq  <= rem_ack;
                retries  <= retries + RW'(1);
                backoff  <= (backoff == BO_MAX) ? BO_MAX : backoff + BW'(1);
              end
            end else begin
              timer <= timer + 32'd1;
            end
          end

          S_RTX: begin
            if (all_acked) begin
              state   <= S_IDLE;
              rtx_req <= 1'b0;
            end else if (rtx_done) begin
              state   <= S_WAIT;
              rtx_req <= 1'b0;
              timer   <= 32'd0;
              dup_cnt <= '0;
            end
          end

          S_ABORT: begin
            abort   <= 1'b1;
            rtx_req <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcp_vlg_ack_proc.sv
// tb/tb_tcp_vlg_ack_proc.sv - self-checking bench for tcp_vlg_ack_proc
module tb_tcp_vlg_ack_proc;

  localparam int RTO  = 40;
  localparam int MAXB = 4;
  localparam int RET  = 6;
  localparam int DUP  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic [31:0] init_seq = 32'd0;
  logic        connected = 1'b0;
  logic        rx_val = 1'b0;
  logic        rx_ack_flag = 1'b0;
  logic [31:0] rx_ack_num = 32'd0;
  logic [15:0] rx_pld_len = 16'd0;
  logic        tx_sent = 1'b0;
  logic [31:0] tx_seq_end = 32'd0;
  logic        rtx_done = 1'b0;
  logic        rtx_req, rtx_fast, all_acked, abort;
  logic [31:0] rtx_seq, rem_ack, in_flight;

  int checks = 0;
  int errors = 0;

  tcp_vlg_ack_proc #(
    .RTO_INIT(RTO), .MAX_BACKOFF(MAXB), .RETRIES(RET), .DUP_ACKS(DUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .init_seq(init_seq),
    .connected(connected), .rx_val(rx_val), .rx_ack_flag(rx_ack_flag),
    .rx_ack_num(rx_ack_num), .rx_pld_len(rx_pld_len), .tx_sent(tx_sent),
    .tx_seq_end(tx_seq_end), .rtx_req(rtx_req), .rtx_fast(rtx_fast),
    .rtx_seq(rtx_seq), .rtx_done(rtx_done), .rem_ack(rem_ack),
    .in_flight(in_flight), .all_acked(all_acked), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_init(input logic [31:0] s);
    init = 1'b1; init_seq = s;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic pulse_tx(input logic [31:0] e);
    tx_sent = 1'b1; tx_seq_end = e;
    @(negedge clk);
    tx_sent = 1'b0;
  endtask

  task automatic send_ack(input logic [31:0] num, input logic [15:0] len);
    rx_val = 1'b1; rx_ack_flag = 1'b1; rx_ack_num = num; rx_pld_len = len;
    @(negedge clk);
    rx_val = 1'b0; rx_ack_flag = 1'b0;
  endtask

  task automatic pulse_done();
    rtx_done = 1'b1;
    @(negedge clk);
    rtx_done = 1'b0;
  endtask

  task automatic wait_evt(input int budget, output int n);
    n = 0;
    while (!(rtx_req || abort) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, bo, cat, off;
    logic [31:0] m_rem, m_loc, num;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rem_ack", rem_ack, 32'd0);
    chk("rst_in_flight", in_flight, 32'd0);
    chk("rst_all_acked", 32'(all_acked), 32'd1);
    chk("rst_rtx_req", 32'(rtx_req), 32'd0);
    chk("rst_rtx_fast", 32'(rtx_fast), 32'd0);
    chk("rst_rtx_seq", rtx_seq, 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    rst_n = 1'b1; connected = 1'b1;
    @(negedge clk);

    // Plain ack of all sent data
    do_init(32'h1000);
    pulse_tx(32'h1400);
    repeat (3) @(negedge clk);
    chk("t1_in_flight_pre", in_flight, 32'h400);
    send_ack(32'h1400, 16'd0);
    @(negedge clk);
    chk("t1_rem_ack", rem_ack, 32'h1400);
    chk("t1_in_flight", in_flight, 32'd0);
    chk("t1_all_acked", 32'(all_acked), 32'd1);
    chk("t1_rtx_req", 32'(rtx_req), 32'd0);

    // Fast retransmit after three zero-length duplicates
    do_init(32'h1000);
    pulse_tx(32'h1800);
    repeat (2) @(negedge clk);
    send_ack(32'h1200, 16'd0);
    chk("fast_rem_ack", rem_ack, 32'h1200);
    for (int i = 0; i < DUP - 1; i++) send_ack(32'h1200, 16'd0);
    chk("fast_early", 32'(rtx_req), 32'd0);
    send_ack(32'h1200, 16'd0);
    chk("fast_req", 32'(rtx_req), 32'd1);
    chk("fast_flag", 32'(rtx_fast), 32'd1);
    chk("fast_seq", rtx_seq, 32'h1200);
    pulse_done();
    chk("fast_done_drop", 32'(rtx_req), 32'd0);
    // Retries/backoff untouched: next timeout comes after a base RTO
    wait_evt(4 * RTO, n);
    chk("fast_no_backoff", 32'(n), 32'(RTO));
    chk("fast_then_timeout", 32'(rtx_fast), 32'd0);
    chk("fast_then_seq", rtx_seq, 32'h1200);
    // Ack during RTX moves rem_ack but not rtx_seq; full ack drops request
    send_ack(32'h1300, 16'd16);
    chk("rtx_ack_rem", rem_ack, 32'h1300);
    chk("rtx_ack_seq", rtx_seq, 32'h1200);
    chk("rtx_ack_req", 32'(rtx_req), 32'd1);
    send_ack(32'h1800, 16'd0);
    @(negedge clk);
    chk("rtx_all_acked_req", 32'(rtx_req), 32'd0);
    chk("rtx_all_acked", 32'(all_acked), 32'd1);

    // Sequence wrap, ack beyond loc_seq, disconnected ack
    do_init(32'hFFFFFF00);
    pulse_tx(32'h00000100);
    send_ack(32'h00000080, 16'd0);
    chk("wrap_rem_ack", rem_ack, 32'h80);
    chk("wrap_in_flight", in_flight, 32'h80);
    send_ack(32'h00000200, 16'd0);
    chk("wrap_beyond", rem_ack, 32'h80);
    connected = 1'b0;
    send_ack(32'h00000100, 16'd0);
    chk("disc_ignored", rem_ack, 32'h80);
    connected = 1'b1;
    send_ack(32'h00000100, 16'd0);
    chk("wrap_full_rem", rem_ack, 32'h100);
    chk("wrap_full_acked", 32'(all_acked), 32'd1);

    // Randomized sends/acks against a window model (short enough to stay under RTO)
    for (int r = 0; r < 2; r++) begin
      m_rem = (r == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2000)) : 32'($urandom);
      m_loc = m_rem;
      do_init(m_rem);
      for (int i = 0; i < 14; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          m_loc = m_loc + 32'($urandom_range(1, 256));
          pulse_tx(m_loc);
        end else begin
          cat = $urandom_range(0, 2);
          if (cat == 0) begin
            off = $urandom_range(0, m_loc - m_rem);
            num = m_rem + 32'(off);
          end else if (cat == 1) begin
            off = 1;
            num = m_loc + 32'($urandom_range(1, 1000));
          end else begin
            off = 1;
            num = m_rem - 32'($urandom_range(1, 1000));
          end
          send_ack(num, 16'($urandom_range(1, 1460)));
          if (cat == 0 && off > 0) m_rem = num;
        end
        @(negedge clk);
        chk("rand_rem_ack", rem_ack, m_rem);
        chk("rand_in_flight", in_flight, m_loc - m_rem);
      end
      chk("rand_no_rtx", 32'(rtx_req), 32'd0);
      send_ack(m_loc, 16'd0);
      chk("rand_final_acked", 32'(all_acked), 32'd1);
    end

    // Timeout backoff and abort after the retry budget
    do_init(32'h1000);
    pulse_tx(32'h1400);
    for (int t = 1; t <= RET; t++) begin
      bo = (t - 1 < MAXB) ? t - 1 : MAXB;
      wait_evt(2 * (RTO << MAXB), n);
      if (t == 1) chk("rto_first", 32'(n >= RTO && n <= RTO + 2), 32'd1);
      else        chk("rto_period", 32'(n), 32'(RTO << bo));
      if (t < RET) begin
        chk("rto_req", 32'(rtx_req), 32'd1);
        chk("rto_fast", 32'(rtx_fast), 32'd0);
        chk("rto_seq", rtx_seq, 32'h1000);
        chk("rto_no_abort", 32'(abort), 32'd0);
        pulse_done();
      end else begin
        chk("abort_set", 32'(abort), 32'd1);
        chk("abort_req", 32'(rtx_req), 32'd0);
      end
    end
    repeat (5) @(negedge clk);
    chk("abort_sticky", 32'(abort), 32'd1);
    do_init(32'h2000);
    chk("init_clears_abort", 32'(abort), 32'd0);
    chk("init_rem_ack", rem_ack, 32'h2000);

    // Asynchronous reset in the middle of a retransmission request
    pulse_tx(32'h2400);
    wait_evt(4 * RTO, n);
    chk("pre_rst_req", 32'(rtx_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(rtx_req), 32'd0);
    chk("arst_fast", 32'(rtx_fast), 32'd0);
    chk("arst_seq", rtx_seq, 32'd0);
    chk("arst_rem", rem_ack, 32'd0);
    chk("arst_flight", in_flight, 32'd0);
    chk("arst_abort", 32'(abort), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(rtx_req), 32'd0);
    chk("post_rst_acked", 32'(all_acked), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
